// File: rtl/mem_dma.sv
// Word-copy / word-fill DMA engine driving a single-ported memory map.
// Fill mode exists only when MEM_DMA_FILL_EN is defined; otherwise every transfer is a copy.
module mem_dma #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [15:0]      src_addr,
    input  logic [15:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    input  logic [15:0]      fill_value,
    output logic             active,
    output logic             done,
    output logic             mem_load,
    output logic [15:0]      mem_address,
    output logic [15:0]      mem_in,
    input  logic [15:0]      mem_out,
    input  logic             mem_busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] READ    = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]       state;
    logic [15:0]      src_r;
    logic [15:0]      dst_r;
    logic [15:0]      data_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_inc;
    logic             fill_r;
    logic             fill_sel;

`ifdef MEM_DMA_FILL_EN
    assign fill_sel = mode;
`else
    logic unused_cfg;
    assign fill_sel   = 1'b0;
    assign unused_cfg = ^{mode, fill_value};
`endif

    assign cnt_inc = cnt + LEN_W'(1);

    // Memory handshake: a read address is accepted in a READ cycle with
    // mem_busy=0 and its data appears on mem_out the next cycle; a write is
    // accepted in a cycle with mem_load=1 and mem_busy=0. Until accepted, the
    // request (address, data, load) is held unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            src_r  <= '0;
            dst_r  <= '0;
            data_r <= '0;
            len_r  <= '0;
            cnt    <= '0;
            fill_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_r  <= src_addr;
                        dst_r  <= dst_addr;
                        len_r  <= length;
                        cnt    <= '0;
                        fill_r <= fill_sel;
                        data_r <= fill_sel ? fill_value : 16'h0000;
                        if (length == '0)
                            state <= DONE;
                        else if (fill_sel)
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                READ: begin
                    if (!mem_busy)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    data_r <= mem_out;
                    state  <= WRITE;
                end
                WRITE: begin
                    if (!mem_busy) begin
                        src_r <= src_r + 16'd1;
                        dst_r <= dst_r + 16'd1;
                        cnt   <= cnt_inc;
                        // In fill mode data_r still holds fill_value, so WRITE simply repeats.
                        if (cnt_inc == len_r)
                            state <= DONE;
                        else if (!fill_r)
                            state <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        active      = 1'b0;
        done        = 1'b0;
        mem_load    = 1'b0;
        mem_address = 16'h0000;
        mem_in      = 16'h0000;
        case (state)
            READ: begin
                active      = 1'b1;
                mem_address = src_r;
            end
            CAPTURE: begin
                active = 1'b1;
            end
            WRITE: begin
                active      = 1'b1;
                mem_load    = 1'b1;
                mem_address = dst_r;
                mem_in      = data_r;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                active = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 SHALL have parameter: LEN_W, 16, width of the length input and of the internal word counter.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on posedge clk.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-005 SHALL have port: mode  input  1  0 = copy, 1 = fill; sampled with start.
REQ-006 SHALL have port: src_addr  input  16  first source word address (copy); sampled with start.
REQ-007 SHALL have port: dst_addr  input  16  first destination word address; sampled with start.
REQ-008 SHALL have port: length  input  LEN_W  word count; sampled with start.
REQ-009 SHALL have port: fill_value  input  16  word written in fill mode; sampled with start.
REQ-010 SHALL have port: active  output  1  high from the cycle after an accepted start until done.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when a transfer completes.
REQ-012 SHALL have port: mem_load  output  1  write strobe to the memory map.
REQ-013 SHALL have port: mem_address  output  16  word address to the memory map.
REQ-014 SHALL have port: mem_in  output  16  write data to the memory map.
REQ-015 SHALL have port: mem_out  input  16  read data; valid the cycle after the address is presented.
REQ-016 SHALL have port: mem_busy  input  1  memory stall; a write completes only in a cycle with mem_load=1 and mem_busy=0.

Function
REQ-017 SHALL implement states IDLE, READ, CAPTURE, WRITE, DONE.
REQ-018 IDLE: on start=1, latch all inputs, zero the counter, and go to READ (copy) or WRITE (fill); if length=0, go to DONE instead.
REQ-019 READ: drive mem_address=current source, mem_load=0; if mem_busy=0, go to CAPTURE; otherwise hold.
REQ-020 CAPTURE: latch mem_out into the data register (read latency is exactly one cycle), then go to WRITE.
REQ-021 WRITE: drive mem_address=current destination, mem_in=data register (or fill_value), mem_load=1; keep address, data, and load stable while mem_busy=1.
REQ-022 On write completion: increment source, destination, and counter; when counter+1=length, go to DONE; otherwise go to READ (copy) or remain in WRITE (fill).
REQ-023 DONE: assert done=1 for exactly one cycle, then return to IDLE.
REQ-024 Throughput with mem_busy=0: copy 3 cycles/word; fill 1 cycle/word.
REQ-025 Addresses SHALL wrap modulo 2^16 (0xFFFF+1=0x0000).
REQ-026 start while not IDLE SHALL be ignored.
REQ-027 mem_load SHALL be 0 in every state except WRITE.
REQ-028 Each destination word SHALL be written exactly once; stalls SHALL cause no duplicate or skipped words.

Reset
REQ-029 reset=1 SHALL force IDLE with active=0, done=0, mem_load=0, mem_address=0, mem_in=0, and counter=0.
REQ-030 Reset mid-transfer SHALL abort with no further write and no done pulse; reset overrides a simultaneous start.

Configuration
REQ-031 With MEM_DMA_FILL_EN defined, mode=1 SHALL perform fill per REQ-018/REQ-022.
REQ-032 Without MEM_DMA_FILL_EN, mode and fill_value SHALL be ignored and every transfer SHALL be a copy; the ports remain.

Verification
REQ-033 Copy: src=0x0010, dst=0x0100, length=4, memory preloaded 1..4, mem_busy=0 -> 0x0100..0x0103 = 1..4, done 13 cycles after start, active high 12 cycles.
REQ-034 Fill (macro on): dst=0x4000, length=3, fill_value=0xFFFF -> three writes on consecutive cycles; done on the next cycle.
REQ-035 Stall: mem_busy=1 for 5 cycles during the second write of a copy -> address/data/load held; exactly one write per word; done delayed 5 cycles.
REQ-036 Zero length: start with length=0 -> no mem_load; done on the cycle after start.
REQ-037 Wrap: copy dst=0xFFFF, length=2 -> writes to 0xFFFF then 0x0000.
REQ-038 Reset after the first write of a length-8 copy -> mem_load=0 next cycle, no done; a later start works normally.
